// File: rtl/trinity_tile_exec.sv
// Trinity tile exec unit: filters broadcast mode/exec frames by group and runs one
// ADD/MUL/MAC/CLR operation per accepted exec pulse on locally supplied operands.
module trinity_tile_exec #(
  parameter logic [1:0] GROUP_ID = 2'b00
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  bus_in,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic [15:0] result,
  output logic [1:0]  result_mode,
  output logic [1:0]  cur_mode,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [7:0]  exec_count
);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_MUL = 2'b01, OP_MAC = 2'b10, OP_CLR = 2'b11} op_t;

  state_t      state, state_next;
  op_t         op_mode;
  logic [7:0]  a_q, b_q;
  logic [2:0]  iter;
  logic [15:0] prod, acc;
  logic [15:0] addend, mul_sum, mac_sum, add_sum;
  logic        frame_match, exec_accept, exec_reject, last_iter;
  logic        unused_reserved;

  assign unused_reserved = bus_in[6];

  assign frame_match = bus_in[7] && (bus_in[5:4] == GROUP_ID) && !bus_in[3];
  assign exec_accept = frame_match && bus_in[2] && (state == IDLE);
  assign exec_reject = frame_match && bus_in[2] && (state == RUN);

  // Shift-add multiplier: one bit of b per RUN cycle, LSB first.
  assign addend  = b_q[iter] ? ({8'd0, a_q} << iter) : 16'd0;
  assign mul_sum = prod + addend;
  assign mac_sum = acc + mul_sum;
  assign add_sum = {8'd0, a_q} + {8'd0, b_q};

  assign last_iter = ((op_mode == OP_ADD) || (op_mode == OP_CLR)) ? (iter == 3'd0) : (iter == 3'd7);
  assign busy      = (state == RUN);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE: if (exec_accept) state_next = RUN;
      RUN:  if (last_iter)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every register here, operands included, is async-reset so an aborted
  // operation leaves nothing behind; sequential state uses non-blocking assigns only.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      op_mode     <= OP_ADD;
      iter        <= '0;
      prod        <= '0;
      acc         <= '0;
      result      <= '0;
      result_mode <= '0;
      cur_mode    <= '0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      exec_count  <= '0;
    end else begin
      done <= 1'b0;
      if (frame_match) cur_mode <= bus_in[1:0];

      if (exec_accept) begin
        a_q        <= op_a;
        b_q        <= op_b;
        op_mode    <= op_t'(bus_in[1:0]);
        iter       <= '0;
        prod       <= '0;
        exec_count <= exec_count + 8'd1;
        overrun    <= 1'b0;
      end else if (exec_reject) begin
        overrun <= 1'b1;
      end

      if (state == RUN) begin
        iter <= iter + 3'd1;
        prod <= mul_sum;
        if (last_iter) begin
          done        <= 1'b1;
          result_mode <= op_mode;
          unique case (op_mode)
            OP_ADD: result <= add_sum;
            OP_MUL: result <= mul_sum;
            OP_MAC: begin
              result <= mac_sum;
              acc    <= mac_sum;
            end
            OP_CLR: begin
              result <= '0;
              acc    <= '0;
            end
            default: result <= result;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_trinity_tile_exec.sv
// Self-checking bench for trinity_tile_exec: table-driven exec vectors plus
// hand-written overrun, filtering and mid-operation reset sequences.
module tb_trinity_tile_exec;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  bus_in, op_a, op_b;
  logic [15:0] result;
  logic [1:0]  result_mode, cur_mode;
  logic        busy, done, overrun;
  logic [7:0]  exec_count;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  int lat;

  trinity_tile_exec #(.GROUP_ID(2'b00)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus_in(bus_in), .op_a(op_a), .op_b(op_b),
    .result(result), .result_mode(result_mode), .cur_mode(cur_mode), .busy(busy),
    .done(done), .overrun(overrun), .exec_count(exec_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0]  frame;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_result;
    logic [1:0]  exp_mode;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Waits edge by edge for done; a timeout leaves lat at the bound and fails the latency check.
  task automatic wait_done(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n++;
      if (done) break;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result"}, result, 0);
    check({tag, "_result_mode"}, result_mode, 0);
    check({tag, "_cur_mode"}, cur_mode, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_exec_count"}, exec_count, 0);
  endtask

  initial begin
    vecs[0] = '{8'h84, 8'd200, 8'd100, 16'd300,   2'd0, 1};
    vecs[1] = '{8'h85, 8'd13,  8'd11,  16'd143,   2'd1, 8};
    vecs[2] = '{8'h86, 8'd200, 8'd200, 16'd40000, 2'd2, 8};
    vecs[3] = '{8'h86, 8'd200, 8'd200, 16'd14464, 2'd2, 8};
    vecs[4] = '{8'h87, 8'd9,   8'd9,   16'd0,     2'd3, 1};
    vecs[5] = '{8'h86, 8'd3,   8'd5,   16'd15,    2'd2, 8};
    vecs[6] = '{8'h84, 8'd255, 8'd255, 16'd510,   2'd0, 1};
    vecs[7] = '{8'h85, 8'd255, 8'd255, 16'd65025, 2'd1, 8};
    vecs[8] = '{8'h86, 8'd1,   8'd1,   16'd16,    2'd2, 8};
    vecs[9] = '{8'h87, 8'd0,   8'd0,   16'd0,     2'd3, 1};

    sys_rst_n = 1'b0;
    bus_in = 8'h00;
    op_a = 8'h00;
    op_b = 8'h00;
    #22;
    check_all_zero("reset");
    tick();
    sys_rst_n = 1'b1;
    tick();

    // Table vectors run back-to-back: the next exec is driven in the done cycle.
    for (int i = 0; i < 10; i++) begin
      bus_in = vecs[i].frame;
      op_a = vecs[i].a;
      op_b = vecs[i].b;
      exp_cnt++;
      tick();
      bus_in = 8'h00;
      op_a = 8'hA5;
      op_b = 8'h5A;
      check($sformatf("v%0d_busy_after_accept", i), busy, 1);
      check($sformatf("v%0d_done_low_after_accept", i), done, 0);
      check($sformatf("v%0d_cur_mode", i), cur_mode, vecs[i].exp_mode);
      check($sformatf("v%0d_exec_count", i), exec_count, exp_cnt);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_result", i), result, vecs[i].exp_result);
      check($sformatf("v%0d_result_mode", i), result_mode, vecs[i].exp_mode);
      check($sformatf("v%0d_busy_at_done", i), busy, 0);
    end
    tick();
    check("done_one_cycle", done, 0);

    // Exec while MUL is running is ignored but flags overrun.
    bus_in = 8'h85; op_a = 8'd7; op_b = 8'd9;
    exp_cnt++;
    tick();
    bus_in = 8'h00;
    tick();
    bus_in = 8'h84; op_a = 8'd50; op_b = 8'd50;
    tick();
    bus_in = 8'h00;
    check("ovr_flag", overrun, 1);
    check("ovr_cur_mode", cur_mode, 0);
    check("ovr_exec_count", exec_count, exp_cnt);
    check("ovr_still_busy", busy, 1);
    wait_done(lat);
    check("ovr_mul_latency", lat, 6);
    check("ovr_mul_result", result, 63);
    check("ovr_mul_result_mode", result_mode, 1);
    check("ovr_sticky", overrun, 1);
    bus_in = 8'h84; op_a = 8'd2; op_b = 8'd3;
    exp_cnt++;
    tick();
    bus_in = 8'h00;
    check("ovr_cleared", overrun, 0);
    wait_done(lat);
    check("ovr_next_result", result, 5);

    // Non-exec matched frame updates cur_mode; filtered frames change nothing.
    bus_in = 8'h83;
    tick();
    bus_in = 8'h00;
    check("mode_only_cur_mode", cur_mode, 3);
    check("mode_only_no_busy", busy, 0);
    check("mode_only_exec_count", exec_count, exp_cnt);
    begin
      logic [7:0] filt[3];
      filt[0] = 8'h94;
      filt[1] = 8'h8C;
      filt[2] = 8'h04;
      for (int j = 0; j < 3; j++) begin
        bus_in = filt[j];
        tick();
        bus_in = 8'h00;
        check($sformatf("filt%0d_busy", j), busy, 0);
        check($sformatf("filt%0d_cur_mode", j), cur_mode, 3);
        check($sformatf("filt%0d_exec_count", j), exec_count, exp_cnt);
        tick();
        check($sformatf("filt%0d_no_done", j), done, 0);
      end
    end

    // Reset during the 4th cycle of a MUL aborts it.
    bus_in = 8'h85; op_a = 8'd13; op_b = 8'd11;
    tick();
    bus_in = 8'h00;
    tick();
    tick();
    tick();
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    sys_rst_n = 1'b1;
    begin
      int saw_done = 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (done || busy) saw_done++;
      end
      check("midrst_no_done_or_busy", saw_done, 0);
      check("midrst_result_kept_zero", result, 0);
    end

    // First exec after reset release is accepted normally.
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    bus_in = 8'h84; op_a = 8'd1; op_b = 8'd2;
    tick();
    bus_in = 8'h00;
    check("postrst_busy", busy, 1);
    check("postrst_exec_count", exec_count, 1);
    wait_done(lat);
    check("postrst_latency", lat, 1);
    check("postrst_result", result, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trinity_tile_exec.md
Name: trinity_tile_exec

Overview:
- Downstream consumer of the 8-bit mode/exec broadcast frame on the Trinity tile bus. One instance per compute tile.
- Filters frames by group, tracks the current mode, and runs one arithmetic operation per accepted exec pulse on locally supplied operands.
- Results and status go to the tile's readout mux.

Parameters:
- GROUP_ID, 2'b00, group this tile answers to; compared against frame[5:4].

Ports:
- sys_clk  in  1  clock, rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- bus_in  in  8  broadcast frame: [7] valid, [6] reserved (ignored), [5:4] group_id, [3] cfg, [2] exec (one-cycle pulse), [1:0] mode_sel.
- op_a  in  8  operand A, unsigned; sampled only on the exec accept edge.
- op_b  in  8  operand B, unsigned; sampled only on the exec accept edge.
- result  out  16  last completed result.
- result_mode  out  2  mode that produced result.
- cur_mode  out  2  mode_sel from the last matched frame.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when result updates.
- overrun  out  1  sticky flag: an exec arrived while busy.
- exec_count  out  8  number of accepted execs, wraps 255->0.

Behaviour:
- Reset values: all outputs 0; internal accumulator 0; FSM in IDLE.
- Reset mid-operation aborts the operation: no done pulse, and result is not updated with partial data.
- Frame match: valid=1 AND group_id==GROUP_ID AND cfg=0. All other frames have no effect.
- Mode tracking: on every matched frame, cur_mode <= mode_sel. This takes effect at the next edge and applies whether or not exec is set.
- Exec accept occurs at an edge where the frame matches, exec=1 and the FSM is in IDLE. On that edge:
  - op_a and op_b are captured.
  - The op mode is taken from the same frame's mode_sel, not the old cur_mode.
  - exec_count increments and overrun clears.
  - FSM moves to RUN.
- Exec while in RUN: the frame is ignored for exec (cur_mode still updates), overrun <= 1, exec_count unchanged.
- Modes and latency L, counted from the accept edge:
  - 00 ADD: result = zero-extended a+b (9-bit sum). L=1.
  - 01 MUL: result = a*b via shift-add, one bit of b per cycle, LSB first. L=8.
  - 10 MAC: acc = (acc + a*b) mod 2^16 via the same shift-add; result = new acc. L=8.
  - 11 CLR: acc = 0, result = 0. L=1.
- FSM states: IDLE -> RUN (on accept) -> IDLE (after L cycles in RUN). A 3-bit iteration counter runs in RUN, 0..L-1.
- Timing, with accept edge = E0:
  - busy=1 after E0 through edge E(L-1).
  - At edge EL: result, result_mode and acc update; done=1 for exactly one cycle; busy=0.
- Back-to-back: the cycle in which done=1 is IDLE, so an exec sampled at edge EL+1 is accepted. Minimum exec spacing is L+1 cycles.
- ADD and MUL do not touch acc. Only MAC and CLR modify acc. acc is not directly visible.
- Frames with valid=0 are fully ignored, even if exec=1.

Test Plan:
- Reset, then matched frame 0x84 (valid, exec, mode 00) with a=200, b=100 -> busy for 1 cycle, then done pulse; result=300, result_mode=0, exec_count=1.
- Frame 0x85 with a=13, b=11 -> busy exactly 8 cycles; done on the 8th edge after accept; result=143; cur_mode=1.
- MAC sequence: 0x86 with a=200, b=200 -> result=40000. Second 0x86 with same operands -> result=14464 (wrap). Then 0x87 -> result=0. Then 0x86 with a=3, b=5 -> result=15.
- While MUL is running, inject 0x84 -> ignored, overrun=1, cur_mode=0, exec_count unchanged. The MUL result is still correct. The next accepted exec clears overrun.
- Filtering (GROUP_ID=0): each of 0x94 (group 1), 0x8C (cfg=1) and 0x04 (valid=0) -> no busy, cur_mode unchanged, exec_count unchanged.
- Assert sys_rst_n low on the 4th cycle of a MUL -> all outputs 0 immediately. After release: no done pulse, and an exec in the first cycle is accepted normally.
